// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory bus controller behind the MEM stage.
// It turns one load or store per instruction into a req/ack bus transaction.
// It places store bytes in their lanes and right-aligns load data.
// While the bus is busy it holds the pipeline through stall_req.
module dmem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr,
  input  logic        rd_en,
  input  logic [1:0]  rd_size,
  input  logic [31:0] ram_waddr,
  input  logic [31:0] ram_wdata,
  input  logic        ram_wreg,
  input  logic [1:0]  st_size,
  input  logic        hold_i,
  output logic [31:0] rdata,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t      state_q, state_d;

  logic        sel_st, acc_valid, acc_mis, acc_go;
  logic [31:0] acc_addr;
  logic [1:0]  acc_size;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;

  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic [7:0]  wait_cnt;
  logic        in_wait, timeout_hit;
  logic [31:0] rd_shift, rd_aligned, rdata_q;

  // Select the access this cycle (a store beats a load) and decode its alignment, lanes and data.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    acc_mis   = 1'b0;
    acc_be    = 4'b1111;
    acc_wdata = ram_wdata;
    sel_st    = ram_wreg;
    acc_valid = ram_wreg | rd_en;
    acc_addr  = sel_st ? ram_waddr : raddr;
    acc_size  = sel_st ? st_size : rd_size;
    case (acc_size)
      2'b00: begin
        acc_be    = 4'b0001 << acc_addr[1:0];
        acc_wdata = {4{ram_wdata[7:0]}};
      end
      2'b01: begin
        acc_mis   = acc_addr[0];
        acc_be    = 4'b0011 << acc_addr[1:0];
        acc_wdata = {2{ram_wdata[15:0]}};
      end
      2'b10:   acc_mis = |acc_addr[1:0];
      default: acc_mis = 1'b1;
    endcase
    acc_go = acc_valid & ~acc_mis;
  end

  assign in_wait     = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign timeout_hit = in_wait && (wait_cnt == 8'(TIMEOUT - 1));

  // Right-align the returned word for the latched offset and clear the bits above the access size.
  always_comb begin
    rd_shift = bus_rdata >> {lat_off, 3'b000};
    case (lat_size)
      2'b00:   rd_aligned = {24'h0, rd_shift[7:0]};
      2'b01:   rd_aligned = {16'h0, rd_shift[15:0]};
      default: rd_aligned = rd_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: launch, wait for ack or timeout, then park in DONE until the pipeline moves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (acc_go) state_d = sel_st ? WR_WAIT : RD_WAIT;
      RD_WAIT, WR_WAIT: if (bus_ack || timeout_hit) state_d = DONE;
      DONE:             if (!hold_i) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Combinational outputs: stall while a transaction is pending, flag misalignment on the spot.
  always_comb begin
    stall_req = 1'b0;
    misalign  = 1'b0;
    rdata     = rdata_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (acc_go) begin
            stall_req = 1'b1;
          end else if (acc_valid) begin
            misalign = 1'b1;
            rdata    = 32'h0;
          end
        end
        RD_WAIT, WR_WAIT: stall_req = 1'b1;
        default: ;
      endcase
    end
  end

  // Bus request fields, wait counter, load data and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      lat_off   <= 2'b00;
      lat_size  <= 2'b00;
      wait_cnt  <= 8'h0;
      rdata_q   <= 32'h0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc_go) begin
            bus_req   <= 1'b1;
            bus_we    <= sel_st;
            bus_addr  <= {acc_addr[31:2], 2'b00};
            bus_be    <= acc_be;
            bus_wdata <= acc_wdata;
            lat_off   <= acc_addr[1:0];
            lat_size  <= acc_size;
            wait_cnt  <= 8'h0;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (state_q == RD_WAIT) rdata_q <= rd_aligned;
          end else if (timeout_hit) begin
            bus_req <= 1'b0;
            rdata_q <= 32'h0;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl.
// Each access is expanded into an expected cycle-by-cycle trace built from the bus protocol rules.
// A single negedge process compares the DUT outputs against that trace.
module tb_dmem_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr, ram_waddr, ram_wdata, bus_rdata;
  logic        rd_en, ram_wreg, hold_i, bus_ack;
  logic [1:0]  rd_size, st_size;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall_req, misalign, bus_err, bus_req, bus_we;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rd_en(rd_en), .rd_size(rd_size),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wreg(ram_wreg), .st_size(st_size),
    .hold_i(hold_i), .rdata(rdata), .stall_req(stall_req), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic rst, rd_en; logic [31:0] raddr; logic [1:0] rd_size;
    logic wreg; logic [31:0] waddr, wdata; logic [1:0] st_size;
    logic hold, ack; logic [31:0] brd;
  } stim_t;

  typedef struct {
    logic stall, misal, err, req;
    logic chk_bus; logic we; logic [31:0] addr; logic [3:0] be;
    logic chk_wd; logic [31:0] wdata;
    logic chk_rd; logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0, n_pass = 0;
  int          stall_cycles = 0, req_pulses = 0, err_pulses = 0;
  logic        req_prev = 1'b0;
  logic [31:0] snap_addr = 0, snap_wdata = 0, snap_rdata = 0;
  logic [3:0]  snap_be = 0;
  logic        snap_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
  endtask

  // Model: lanes, replicated data and aligned load value from plain arithmetic.
  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [1:0] sz, input logic [1:0] off,
                                              input logic [31:0] brd);
    logic [31:0] v;
    v = brd >> (8 * off);
    if (sz == 2'd0) return v & 32'hFF;
    if (sz == 2'd1) return v & 32'hFFFF;
    return v;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic exp_t mk_exp(input bit stall, input bit misal, input bit err, input bit req);
    exp_t e;
    e = '{default: 0};
    e.stall = stall; e.misal = misal; e.err = err; e.req = req;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; rd_en = s.rd_en; raddr = s.raddr; rd_size = s.rd_size;
    ram_wreg = s.wreg; ram_waddr = s.waddr; ram_wdata = s.wdata; st_size = s.st_size;
    hold_i = s.hold; bus_ack = s.ack; bus_rdata = s.brd;
  endtask

  task automatic cyc(input stim_t s, input exp_t e);
    drive(s);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // One access: k = ack in the k-th wait cycle (0 = never), hold = cycles hold_i stays high in DONE.
  task automatic do_access(input bit st, input bit both, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd, input logic [31:0] brd, input int k, input int hold);
    stim_t sa, s;
    exp_t e;
    logic [1:0] off;
    bit mis;
    int w_cycles;
    off = a[1:0];
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 2'd0);
    sa = quiet();
    if (st) begin
      sa.wreg = 1; sa.waddr = a; sa.wdata = wd; sa.st_size = sz;
      if (both) begin sa.rd_en = 1; sa.raddr = 32'h9001; sa.rd_size = 2'd2; end
    end else begin
      sa.rd_en = 1; sa.raddr = a; sa.rd_size = sz;
    end
    e = mk_exp(!mis, mis, 0, 0);
    if (mis) e.chk_rd = 1;
    cyc(sa, e);
    if (mis) return;
    w_cycles = (k > 0) ? k : TO;
    for (int w = 1; w <= w_cycles; w++) begin
      s = sa; s.ack = (w == k); s.brd = brd;
      e = mk_exp(1, 0, 0, 1);
      e.chk_bus = 1; e.we = st; e.addr = {a[31:2], 2'b00}; e.be = model_be(sz, off);
      e.chk_wd = st; e.wdata = model_wdata(sz, wd);
      cyc(s, e);
    end
    for (int d = 0; d <= hold; d++) begin
      s = (d < hold) ? sa : quiet();
      s.hold = (d < hold); s.brd = 32'hDEAD_BEEF ^ 32'(d);
      e = mk_exp(0, 0, (k == 0) && (d == 0), 0);
      if (!st) begin e.chk_rd = 1; e.rdata = (k == 0) ? 32'h0 : model_rdata(sz, off, brd); end
      cyc(s, e);
    end
  endtask

  // Compare process: one expected entry per queued cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall_req", 32'(stall_req), 32'(e.stall));
      check("misalign", 32'(misalign), 32'(e.misal));
      check("bus_err", 32'(bus_err), 32'(e.err));
      check("bus_req", 32'(bus_req), 32'(e.req));
      if (e.chk_bus) begin
        check("bus_we", 32'(bus_we), 32'(e.we));
        check("bus_addr", bus_addr, e.addr);
        check("bus_be", 32'(bus_be), 32'(e.be));
      end
      if (e.chk_wd) check("bus_wdata", bus_wdata, e.wdata);
      if (e.chk_rd) begin
        check("rdata", rdata, e.rdata);
        snap_rdata = rdata;
      end
      if (stall_req) stall_cycles++;
      if (bus_err) err_pulses++;
      if (bus_req && !req_prev) req_pulses++;
      if (bus_req) begin
        snap_addr = bus_addr; snap_be = bus_be; snap_wdata = bus_wdata; snap_we = bus_we;
      end
    end
    req_prev = bus_req;
  end

  initial begin
    stim_t s;
    exp_t e;
    int b_st, b_rq, b_er;

    // Reset with a misaligned load presented: combinational outputs must stay low.
    s = quiet(); s.rst = 1; s.rd_en = 1; s.raddr = 32'h1; s.rd_size = 2'd2;
    drive(s);
    @(posedge clk); #1;
    e = mk_exp(0, 0, 0, 0); e.chk_bus = 1; e.chk_wd = 1; e.chk_rd = 1;
    cyc(s, e);
    s = quiet(); s.ack = 1;
    cyc(s, e);

    // Store byte, zero-wait slave.
    b_st = stall_cycles; b_rq = req_pulses;
    do_access(1, 0, 32'h1002, 2'd0, 32'hAABB_CCDD, 32'h0, 1, 0);
    check("st_byte_addr", snap_addr, 32'h0000_1000);
    check("st_byte_be", 32'(snap_be), 32'h4);
    check("st_byte_wdata", snap_wdata, 32'hDDDD_DDDD);
    check("st_byte_we", 32'(snap_we), 32'h1);
    check("st_byte_stalls", 32'(stall_cycles - b_st), 32'd2);
    check("st_byte_pulses", 32'(req_pulses - b_rq), 32'd1);

    // Load half, ack in the third wait cycle.
    b_st = stall_cycles;
    do_access(0, 0, 32'h2002, 2'd1, 32'h0, 32'h8765_4321, 3, 0);
    check("ld_half_rdata", snap_rdata, 32'h0000_8765);
    check("ld_half_stalls", 32'(stall_cycles - b_st), 32'd4);

    // Misaligned word load: no bus traffic, no stall.
    b_st = stall_cycles; b_rq = req_pulses;
    do_access(0, 0, 32'h3001, 2'd2, 32'h0, 32'h0, 1, 0);
    check("mis_stalls", 32'(stall_cycles - b_st), 32'd0);
    check("mis_pulses", 32'(req_pulses - b_rq), 32'd0);
    s = quiet(); s.ack = 1;
    cyc(s, mk_exp(0, 0, 0, 0));

    // Held in DONE for three cycles with the access still presented.
    b_rq = req_pulses;
    do_access(0, 0, 32'h6003, 2'd0, 32'h0, 32'h1122_3344, 2, 3);
    check("hold_pulses", 32'(req_pulses - b_rq), 32'd1);
    check("hold_rdata", snap_rdata, 32'h0000_0011);

    // Reset in RD_WAIT, then a stray ack.
    s = quiet(); s.rd_en = 1; s.raddr = 32'h5004; s.rd_size = 2'd2;
    cyc(s, mk_exp(1, 0, 0, 0));
    cyc(s, mk_exp(1, 0, 0, 1));
    cyc(s, mk_exp(1, 0, 0, 1));
    s.rst = 1;
    cyc(s, mk_exp(0, 0, 0, 1));
    s = quiet(); s.ack = 1;
    e = mk_exp(0, 0, 0, 0); e.chk_bus = 1; e.chk_wd = 1; e.chk_rd = 1;
    cyc(s, e);
    s.ack = 0;
    cyc(s, e);

    // Store half with a (misaligned) load alongside: the store wins.
    do_access(1, 1, 32'h700A, 2'd1, 32'h1234_5678, 32'h0, 2, 0);
    check("st_half_be", 32'(snap_be), 32'hC);
    check("st_half_wdata", snap_wdata, 32'h5678_5678);

    do_access(1, 0, 32'h8000, 2'd2, 32'hCAFE_BABE, 32'h0, 1, 0);
    do_access(0, 0, 32'hC000, 2'd2, 32'h0, 32'hCAFE_F00D, 1, 0);
    check("ld_word_rdata", snap_rdata, 32'hCAFE_F00D);

    // Timeout: no ack for TO wait cycles.
    b_st = stall_cycles; b_er = err_pulses;
    do_access(0, 0, 32'h4000, 2'd2, 32'h0, 32'h0, 0, 0);
    check("to_stalls", 32'(stall_cycles - b_st), 32'd5);
    check("to_err_pulses", 32'(err_pulses - b_er), 32'd1);
    check("to_rdata", snap_rdata, 32'h0);

    do_access(1, 0, 32'h0100, 2'd3, 32'h0, 32'h0, 1, 0);
    do_access(0, 0, 32'h2001, 2'd1, 32'h0, 32'h0, 1, 0);
    do_access(0, 0, 32'h2001, 2'd0, 32'h0, 32'hA1B2_C3D4, 1, 1);
    check("ld_byte_rdata", snap_rdata, 32'h0000_00C3);

    cyc(quiet(), mk_exp(0, 0, 0, 0));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
